access_router: RTL
==================

Name: access_router

Overview:
- Parametrised successor to the two-register token access controller: authenticates user_token against system_token, then routes confirmed data words into one of NUM_CH channel registers.
- Adds a retry limit with a persistent lockout, a session inactivity timeout, per-channel write strobes and a status readout.
- Sits between the user keypad/token front end and the downstream channel consumers (display/gate logic).

Parameters:
- DATA_W, 8, width of data_in and of each channel register
- TOKEN_W, 3, width of system_token/user_token
- NUM_CH, 2, number of output channels; power of two, >=2; SEL_W = clog2(NUM_CH)
- MAX_TRIES, 3, failed authentications before lockout; >=1
- TIMEOUT, 16, idle SESSION cycles before forced return to IDLE; >=2

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; priority over every other input
- request  in  1  session request; level-sensitive
- confirm  in  1  qualifies user_token in AUTH and data_in in SESSION
- system_token  in  TOKEN_W  expected token
- user_token  in  TOKEN_W  presented token
- data_in  in  DATA_W  word to route; channel index = data_in[DATA_W-1 -: SEL_W]
- data_out  out  NUM_CH*DATA_W  channel registers, channel k at [k*DATA_W +: DATA_W]
- ch_en  out  NUM_CH  channel write-enable mask
- wr_strobe  out  NUM_CH  one-cycle pulse on channel k when it is loaded
- wr_err  out  1  one-cycle pulse when a write targets a disabled channel
- granted  out  1  high in SESSION
- locked  out  1  high in LOCK
- fail_cnt  out  clog2(MAX_TRIES+1)  failed attempts since last success/reset

Behaviour:
- Reset (sync): state=IDLE; data_out=0; ch_en=0; wr_strobe=0; wr_err=0; granted=0; locked=0; fail_cnt=0; timeout counter=0. Reset mid-session or in LOCK behaves identically.
- Global rule: in AUTH/GRANT/SESSION, request=0 takes priority over confirm: go to IDLE, ch_en<=0, no write. data_out holds its value.
- IDLE: request=1 -> AUTH.
- AUTH: confirm & tokens equal -> GRANT, fail_cnt<=0.
- AUTH: confirm & mismatch -> fail_cnt+1. If the new value == MAX_TRIES -> LOCK, else stay in AUTH (retry without re-request). No confirm -> stay.
- GRANT (one cycle): data_out<=0; ch_en<=all ones; timeout counter<=0 -> SESSION.
- SESSION, confirm, channel s enabled: channel s <= data_in; wr_strobe[s]=1 the next cycle; ch_en<=one-hot(s), so other channels are disabled; timeout counter<=0.
- SESSION, confirm, channel s disabled: no load; wr_err=1 the next cycle; timeout counter<=0.
- SESSION, no confirm: timeout counter+1. When it reaches TIMEOUT-1 and still no confirm -> IDLE, ch_en<=0, so exactly TIMEOUT idle cycles elapse.
- LOCK: locked=1; ignores request, confirm and tokens. Exits only via reset.
- fail_cnt persists across IDLE returns. It is cleared only by a successful authentication or reset, and saturates at MAX_TRIES.
- Latency: a write confirmed at edge N is visible on data_out and wr_strobe after edge N. The status outputs are registered and reflect the current state.

Decomposition:
- Package access_router_pkg: state enum (IDLE, AUTH, GRANT, SESSION, LOCK) with 3-bit encoding; clog2 helper function; SEL_W/CNT_W derivation constants.
- Sub-module channel_reg: DATA_W-wide register with sync clear and load enable, instantiated NUM_CH times via generate.
- FSM, fail counter and timeout counter stay in the top level.

Test Plan:
- Defaults; reset; request=1; confirm with tokens 3'b101/3'b101 -> AUTH, GRANT, SESSION; granted=1; ch_en=2'b11; data_out=16'h0000.
- In SESSION, confirm data_in=8'hF3 -> data_out[15:8]=8'hF3; wr_strobe=2'b10; ch_en=2'b10. Next confirm data_in=8'h12 -> no load; wr_err pulse; data_out[7:0] stays 8'h00.
- Three confirms with system_token=3'b101, user_token=3'b010 -> fail_cnt 1, 2, then LOCK with locked=1. A matching token and request toggling leave it locked; reset -> IDLE, fail_cnt=0.
- Two mismatches, drop request (IDLE), re-request, one mismatch -> LOCK, showing persistence. Separately, two mismatches then a match -> fail_cnt=0.
- SESSION with no confirm for 16 cycles -> IDLE after exactly 16 cycles; ch_en=0; data_out retained. A confirm at cycle 15 restarts the count.
- Same cycle request=0 and confirm with data_in=8'h80 in SESSION -> IDLE; no wr_strobe; data_out unchanged. Assert reset during SESSION -> all outputs zero on the next edge.

Source files
------------

// File: rtl/access_router_pkg.sv
// Shared types and width helpers for the access router and its channel registers.
package access_router_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      AUTH    = 3'd1,
      GRANT   = 3'd2,
      SESSION = 3'd3,
      LOCK    = 3'd4
   } state_t;

   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_TOKEN_W   = 3;
   localparam int unsigned DEF_NUM_CH    = 2;
   localparam int unsigned DEF_MAX_TRIES = 3;
   localparam int unsigned DEF_TIMEOUT   = 16;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r++;
      return r;
   endfunction

   // Channel index width taken from the top of data_in.
   function automatic int unsigned sel_width(input int unsigned num_ch);
      return clog2(num_ch);
   endfunction

   // Fail counter must hold 0..MAX_TRIES inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_tries);
      return clog2(max_tries + 1);
   endfunction

   function automatic int unsigned tmo_width(input int unsigned timeout);
      return clog2(timeout);
   endfunction

endpackage

// File: rtl/access_router_channel_reg.sv
// One channel data register: synchronous clear wins over load.
module channel_reg
   import access_router_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clock) begin
      if (clear)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/access_router.sv
// Token-authenticated router: AUTH/LOCK handling, session timeout, and routing
// of confirmed data words into per-channel registers.
module access_router
   import access_router_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned TOKEN_W   = DEF_TOKEN_W,
   parameter int unsigned NUM_CH    = DEF_NUM_CH,
   parameter int unsigned MAX_TRIES = DEF_MAX_TRIES,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                request,
   input  logic                                confirm,
   input  logic [TOKEN_W-1:0]                  system_token,
   input  logic [TOKEN_W-1:0]                  user_token,
   input  logic [DATA_W-1:0]                   data_in,
   output logic [NUM_CH*DATA_W-1:0]            data_out,
   output logic [NUM_CH-1:0]                   ch_en,
   output logic [NUM_CH-1:0]                   wr_strobe,
   output logic                                wr_err,
   output logic                                granted,
   output logic                                locked,
   output logic [cnt_width(MAX_TRIES)-1:0]     fail_cnt
);

   localparam int unsigned SEL_W = sel_width(NUM_CH);
   localparam int unsigned CNT_W = cnt_width(MAX_TRIES);
   localparam int unsigned TMO_W = tmo_width(TIMEOUT);
   localparam logic [CNT_W-1:0] FAIL_MAX = CNT_W'(MAX_TRIES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   state_t              state;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [SEL_W-1:0]    sel;
   logic [NUM_CH-1:0]   sel_onehot;
   logic [NUM_CH-1:0]   load;
   logic                sel_enabled;
   logic                write_ok;
   logic                clear_ch;
   logic [CNT_W-1:0]    fail_next;
   logic [DATA_W-1:0]   ch_q [NUM_CH];

   assign sel         = data_in[DATA_W-1 -: SEL_W];
   assign sel_onehot  = NUM_CH'(1) << sel;
   assign sel_enabled = ch_en[sel];
   assign write_ok    = (state == SESSION) && request && confirm && sel_enabled;
   assign clear_ch    = reset || ((state == GRANT) && request);
   assign fail_next   = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;

   always_comb begin
      load = '0;
      for (int unsigned k = 0; k < NUM_CH; k++)
         load[k] = write_ok && (sel == SEL_W'(k));
   end

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         channel_reg #(
            .DATA_W (DATA_W)
         ) u_channel_reg (
            .clock (clock),
            .clear (clear_ch),
            .load  (load[g]),
            .d     (data_in),
            .q     (ch_q[g])
         );
         assign data_out[g*DATA_W +: DATA_W] = ch_q[g];
      end
   endgenerate

   // Status outputs are updated alongside state so they track it without extra delay.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         ch_en     <= '0;
         wr_strobe <= '0;
         wr_err    <= 1'b0;
         granted   <= 1'b0;
         locked    <= 1'b0;
         fail_cnt  <= '0;
         tmo_cnt   <= '0;
      end else begin
         wr_strobe <= '0;
         wr_err    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (request)
                  state <= AUTH;
            end
            AUTH: begin
               if (!request) begin
                  state <= IDLE;
                  ch_en <= '0;
               end else if (confirm) begin
                  if (user_token == system_token) begin
                     state    <= GRANT;
                     fail_cnt <= '0;
                  end else begin
                     fail_cnt <= fail_next;
                     if (fail_next == FAIL_MAX) begin
                        state  <= LOCK;
                        locked <= 1'b1;
                     end
                  end
               end
            end
            GRANT: begin
               if (!request) begin
                  state <= IDLE;
                  ch_en <= '0;
               end else begin
                  state   <= SESSION;
                  ch_en   <= '1;
                  tmo_cnt <= '0;
                  granted <= 1'b1;
               end
            end
            SESSION: begin
               if (!request) begin
                  state   <= IDLE;
                  ch_en   <= '0;
                  granted <= 1'b0;
               end else if (confirm) begin
                  tmo_cnt <= '0;
                  if (sel_enabled) begin
                     wr_strobe <= load;
                     ch_en     <= sel_onehot;
                  end else begin
                     wr_err <= 1'b1;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  state   <= IDLE;
                  ch_en   <= '0;
                  granted <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            LOCK: begin
               locked <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               ch_en   <= '0;
               granted <= 1'b0;
               locked  <= 1'b0;
            end
         endcase
      end
   end

endmodule
